// File: rtl/shifter_pkg.sv
// Shared definitions for the two-requester shift arbiter: default data width
// and the controller state encoding.
package shifter_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

endpackage

// File: rtl/right_shifter.sv
// Zero-filling logical right shifter shared by both requesters.
module right_shifter
  import shifter_pkg::*;
#(
  parameter int width = DEFAULT_WIDTH,
  localparam int l = $clog2(width)
) (
  input  logic [width-1:0] i_a,
  input  logic [l-1:0]     i_b,
  output logic [width-1:0] o_y
);

  assign o_y = i_a >> i_b;

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter in front of a single right shifter. One operation is in
// flight at a time; the result is held until the consumer takes it.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for a request; grants one requester combinationally
// ST_SHIFT  | latched operands drive the shifter; result captured at edge
// ST_RESULT | res_valid high, result held until res_ready is sampled
module shift_arbiter
  import shifter_pkg::*;
#(
  parameter int width = DEFAULT_WIDTH,
  localparam int l = $clog2(width)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [width-1:0] req0_a,
  input  logic [l-1:0]     req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [width-1:0] req1_a,
  input  logic [l-1:0]     req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [width-1:0] res_y,
  output logic             res_id
);

  state_t r_state;
  state_t w_state_nxt;

  logic [width-1:0] r_a;
  logic [l-1:0]     r_b;
  logic             r_id;
  logic             r_last;
  logic [width-1:0] r_res_y;
  logic             r_res_id;

  logic             w_grant;
  logic             w_gnt_id;
  logic [width-1:0] w_y;

  // Winner selection: a lone requester always wins; on a tie the one not
  // granted last wins.
  assign w_gnt_id = (req0_valid && req1_valid) ? ~r_last : req1_valid;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (req0_valid || req1_valid) w_state_nxt = ST_SHIFT;
      ST_SHIFT:  w_state_nxt = ST_RESULT;
      ST_RESULT: if (res_ready) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: grant only in IDLE and never while reset is asserted.
  always_comb begin
    w_grant    = 1'b0;
    res_valid  = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (r_state == ST_IDLE) begin
      w_grant = rst_n && (req0_valid || req1_valid);
    end
    if (r_state == ST_RESULT) begin
      res_valid = 1'b1;
    end
    req0_ready = w_grant && !w_gnt_id;
    req1_ready = w_grant &&  w_gnt_id;
  end

  // Operand capture on grant and result capture in SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_id     <= 1'b0;
      r_last   <= 1'b1;
      r_res_y  <= '0;
      r_res_id <= 1'b0;
    end else begin
      if (w_grant) begin
        r_a    <= w_gnt_id ? req1_a : req0_a;
        r_b    <= w_gnt_id ? req1_b : req0_b;
        r_id   <= w_gnt_id;
        r_last <= w_gnt_id;
      end
      if (r_state == ST_SHIFT) begin
        r_res_y  <= w_y;
        r_res_id <= r_id;
      end
    end
  end

  right_shifter #(
    .width(width)
  ) u_right_shifter (
    .i_a(r_a),
    .i_b(r_b),
    .o_y(w_y)
  );

  assign res_y  = r_res_y;
  assign res_id = r_res_id;

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on each result handshake.
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a = '0, req1_a = '0;
  logic [3:0]  req0_b = '0, req1_b = '0;
  logic        res_valid, res_id;
  logic        res_ready = 1'b1;
  logic [15:0] res_y;

  int n_cmp = 0;
  int n_err = 0;
  logic [16:0] sb[$];

  shift_arbiter #(.width(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y), .res_id(res_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic drive(input logic v0, input logic [15:0] a0, input logic [3:0] b0,
                       input logic v1, input logic [15:0] a1, input logic [3:0] b1);
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
  endtask

  // Waits (bounded) for a grant, checks which requester got it, pushes the
  // expected result. k returns the number of negedges waited.
  task automatic expect_grant(input bit id, input logic [15:0] y, input string nm, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(req0_ready || req1_ready) && k < 20);
    chk({nm, "_ready"}, {30'b0, req1_ready, req0_ready}, id ? 32'd2 : 32'd1);
    sb.push_back({id, y});
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: no grants while a result is presented, held result stable,
  // and each taken result matches the scoreboard head.
  initial begin : monitor
    logic        hold;
    logic [16:0] held;
    logic [16:0] e;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        chk("no_ready_in_result", {30'b0, req1_ready, req0_ready}, 0);
        if (hold) chk("hold_stable", {15'b0, res_id, res_y}, {15'b0, held});
        if (res_ready) begin
          if (sb.size() == 0) begin
            chk("sb_nonempty", 32'(sb.size()), 1);
          end else begin
            e = sb.pop_front();
            chk("res_id", res_id, e[16]);
            chk("res_y", res_y, e[15:0]);
          end
          hold = 1'b0;
        end else begin
          hold = 1'b1;
          held = {res_id, res_y};
        end
      end else begin
        hold = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int k;
    logic [15:0] ones;
    ones = 16'hFFFF;

    // Reset with both requesters asserting: nothing granted, outputs zero.
    drive(1, 16'hFFFF, 4, 1, 16'hFFFF, 4);
    #1 rst_n = 1'b0;
    #2;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_y", res_y, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_ready", {30'b0, req1_ready, req0_ready}, 0);
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single op with latency check.
    drive(1, 16'hFFFF, 4, 0, 0, 0);
    expect_grant(0, 16'h0FFF, "t1", k);
    @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("t1_lat_shift", res_valid, 0);
    @(negedge clk); chk("t1_lat_result", res_valid, 1);
    drain();

    // Shift by zero from requester 1 alone (pointer 0 must not block it).
    drive(0, 0, 0, 1, 16'hA5A5, 0);
    expect_grant(1, 16'hA5A5, "b0", k);
    @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0);
    drain();

    // Continuous tie: alternates 0,1,0,1 at one op per 3 cycles.
    drive(1, 16'h1234, 1, 1, 16'hF000, 8);
    for (int i = 0; i < 4; i++) begin
      expect_grant(i[0], i[0] ? 16'h00F0 : 16'h091A, "tie", k);
      if (i > 0) chk("tie_period", k, 3);
    end
    @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0);
    drain();

    // Back-pressure: result held 5 cycles while requester 1 waits.
    res_ready = 1'b0;
    drive(1, 16'h8000, 15, 0, 0, 0);
    expect_grant(0, 16'h0001, "hold", k);
    @(posedge clk); #1 drive(0, 0, 0, 1, 16'h00FF, 3);
    k = 0;
    while (res_valid !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("hold_valid", res_valid, 1);
    repeat (4) @(negedge clk);
    @(posedge clk); #1 res_ready = 1'b1;
    expect_grant(1, 16'h001F, "after_hold", k);
    @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0);
    drain();

    // Sweep of shift amounts.
    for (int b = 0; b < 16; b++) begin
      drive(1, 16'hFFFF, b[3:0], 0, 0, 0);
      expect_grant(0, ones >> b, "sweep", k);
      @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0);
    end
    drain();

    // Reset during SHIFT: op discarded, pointer back to 1 so req0 wins tie.
    drive(1, 16'hBEEF, 4, 0, 0, 0);
    expect_grant(0, 16'h0BEE, "pre_rst", k);
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(1, 16'h0F0F, 2, 1, 16'hFFFF, 15);
    sb.delete(sb.size() - 1);
    #1;
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_res_y", res_y, 0);
    chk("mid_rst_res_id", res_id, 0);
    chk("mid_rst_ready", {30'b0, req1_ready, req0_ready}, 0);
    @(negedge clk);
    chk("mid_rst_ready_hold", {30'b0, req1_ready, req0_ready}, 0);
    chk("mid_rst_valid_hold", res_valid, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    expect_grant(0, 16'h03C3, "tie_after_rst", k);
    @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0);
    drain();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
